// File: rtl/reset_request_if.sv
// Purpose : bundles the request-side signals of reset_request (button, SW strobe, status).
// Latency : n/a, wiring only.
// Backpressure: none; every signal is a level or a single-cycle strobe.
//
// Signals:
//   button          raw asynchronous push-button level (toward the block)
//   sw_reset_req    single-cycle software reset strobe (toward the block)
//   sw_reset_key    8-bit key sampled with sw_reset_req (toward the block)
//   cause_clear     single-cycle strobe that clears reset_cause (toward the block)
//   reset_request   active-high request to the reset generator (from the block)
//   button_pressed  debounced pressed state (from the block)
//   reset_cause     sticky cause, bit0 = button, bit1 = software (from the block)
interface reset_request_if;
  logic       button;
  logic       sw_reset_req;
  logic [7:0] sw_reset_key;
  logic       cause_clear;
  logic       reset_request;
  logic       button_pressed;
  logic [1:0] reset_cause;

  // Driver side: the board/CPU environment.
  modport master (
    output button,
    output sw_reset_req,
    output sw_reset_key,
    output cause_clear,
    input  reset_request,
    input  button_pressed,
    input  reset_cause
  );

  // Receiver side: the reset_request block itself.
  modport slave (
    input  button,
    input  sw_reset_req,
    input  sw_reset_key,
    input  cause_clear,
    output reset_request,
    output button_pressed,
    output reset_cause
  );
endinterface

// File: rtl/reset_request.sv
// Purpose : turns a bouncing push-button and a keyed software strobe into a clean,
//           minimum-width, active-high reset request, with a sticky cause register.
// Latency : button edge -> button_pressed in 2 + DEBOUNCE_CYCLES cycles, request one cycle
//           later; qualifying SW strobe -> request on the next edge.
// Backpressure: none; events arriving while a request is active are dropped.
//
// Ports:
//   clk_1x      system clock
//   reset_1x_n  asynchronous active-low reset from the power-on/PLL path
//   bus_if      reset_request_if.slave (button, sw_reset_req/key, cause_clear in;
//               reset_request, button_pressed, reset_cause out)
module reset_request #(
  parameter int         DEBOUNCE_CYCLES   = 65536,
  parameter int         PULSE_CYCLES      = 64,
  parameter bit         BUTTON_ACTIVE_LOW = 1'b1,
  parameter logic [7:0] SW_KEY            = 8'hA5
) (
  input  logic            clk_1x,
  input  logic            reset_1x_n,
  reset_request_if.slave  bus_if
);

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam int PC_W = (PULSE_CYCLES > 1) ? $clog2(PULSE_CYCLES) : 1;

  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [PC_W-1:0] PC_LOAD = PC_W'(PULSE_CYCLES - 1);

  // Raw level of an unpressed button; the synchroniser resets to it so that a
  // button held through reset is seen as a fresh press afterwards.
  localparam logic BTN_IDLE = BUTTON_ACTIVE_LOW ? 1'b1 : 1'b0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PULSE = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  // ------------------------------------------------------------------
  // Two-flop synchroniser
  // ------------------------------------------------------------------
  logic sync1_q;
  logic sync2_q;
  logic pressed_sync;

  always_ff @(posedge clk_1x or negedge reset_1x_n) begin
    if (!reset_1x_n) begin
      sync1_q <= BTN_IDLE;
      sync2_q <= BTN_IDLE;
    end else begin
      sync1_q <= bus_if.button;
      sync2_q <= sync1_q;
    end
  end

  // Normalise to active-high "pressed".
  assign pressed_sync = sync2_q ^ BTN_IDLE;

  // ------------------------------------------------------------------
  // Debouncer
  // ------------------------------------------------------------------
  logic [DB_W-1:0] db_cnt_q;
  logic [DB_W-1:0] db_cnt_d;
  logic            pressed_q;
  logic            pressed_d;
  logic            pressed_prev_q;

  // The counter measures how long the synced level has disagreed with the
  // debounced state. It toggles the state when it has already counted
  // DEBOUNCE_CYCLES-1 disagreeing cycles and the level still disagrees, i.e.
  // after DEBOUNCE_CYCLES consecutive disagreeing cycles in total.
  always_comb begin
    db_cnt_d  = db_cnt_q;
    pressed_d = pressed_q;
    if (pressed_sync == pressed_q) begin
      db_cnt_d = '0;
    end else if (db_cnt_q == DB_LAST) begin
      pressed_d = ~pressed_q;
      db_cnt_d  = '0;
    end else begin
      db_cnt_d = db_cnt_q + DB_W'(1);
    end
  end

  always_ff @(posedge clk_1x or negedge reset_1x_n) begin
    if (!reset_1x_n) begin
      db_cnt_q       <= '0;
      pressed_q      <= 1'b0;
      pressed_prev_q <= 1'b0;
    end else begin
      db_cnt_q       <= db_cnt_d;
      pressed_q      <= pressed_d;
      pressed_prev_q <= pressed_q;
    end
  end

  // ------------------------------------------------------------------
  // Event detection
  // ------------------------------------------------------------------
  logic btn_event;
  logic sw_event;
  logic any_event;

  // Press only; a release never requests a reset. Taken from the registered
  // debounced state, so the request follows button_pressed by one cycle.
  assign btn_event = pressed_q & ~pressed_prev_q;
  assign sw_event  = bus_if.sw_reset_req & (bus_if.sw_reset_key == SW_KEY);
  assign any_event = btn_event | sw_event;

  // ------------------------------------------------------------------
  // Request FSM and cause register
  // ------------------------------------------------------------------
  state_t          state_q;
  state_t          state_d;
  logic [PC_W-1:0] pulse_cnt_q;
  logic [PC_W-1:0] pulse_cnt_d;
  logic            req_q;
  logic            req_d;
  logic [1:0]      cause_q;
  logic [1:0]      cause_d;

  always_comb begin
    state_d     = state_q;
    pulse_cnt_d = pulse_cnt_q;
    req_d       = req_q;
    cause_d     = cause_q;

    // A clear is overridden below when a new event is accepted in the same cycle.
    if (bus_if.cause_clear) begin
      cause_d = 2'b00;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (any_event) begin
          state_d     = ST_PULSE;
          pulse_cnt_d = PC_LOAD;
          req_d       = 1'b1;
          cause_d     = {sw_event, btn_event};
        end
      end

      ST_PULSE: begin
        // Counter was loaded with PULSE_CYCLES-1 on entry, so the request is
        // high for exactly PULSE_CYCLES cycles unless the button is still held.
        if (pulse_cnt_q == '0) begin
          if (pressed_q) begin
            state_d = ST_HOLD;
          end else begin
            state_d = ST_IDLE;
            req_d   = 1'b0;
          end
        end else begin
          pulse_cnt_d = pulse_cnt_q - PC_W'(1);
        end
      end

      ST_HOLD: begin
        if (!pressed_q) begin
          state_d = ST_IDLE;
          req_d   = 1'b0;
        end
      end

      default: begin
        state_d = ST_IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_1x or negedge reset_1x_n) begin
    if (!reset_1x_n) begin
      state_q     <= ST_IDLE;
      pulse_cnt_q <= '0;
      req_q       <= 1'b0;
      cause_q     <= 2'b00;
    end else begin
      state_q     <= state_d;
      pulse_cnt_q <= pulse_cnt_d;
      req_q       <= req_d;
      cause_q     <= cause_d;
    end
  end

  // All outputs come straight from flops.
  assign bus_if.reset_request  = req_q;
  assign bus_if.button_pressed = pressed_q;
  assign bus_if.reset_cause    = cause_q;

endmodule

// File: tb/tb_reset_request.sv
// Purpose : directed self-checking bench for reset_request (DEBOUNCE=4, PULSE=8, active-low button).
// Latency : n/a.
// Backpressure: n/a.
module tb_reset_request;

  logic clk_1x = 1'b0;
  logic reset_1x_n;

  reset_request_if bus_if ();

  reset_request #(
    .DEBOUNCE_CYCLES   (4),
    .PULSE_CYCLES      (8),
    .BUTTON_ACTIVE_LOW (1'b1),
    .SW_KEY            (8'hA5)
  ) dut (
    .clk_1x     (clk_1x),
    .reset_1x_n (reset_1x_n),
    .bus_if     (bus_if.slave)
  );

  always #5 clk_1x = ~clk_1x;

  int n_checks = 0;
  int n_fail   = 0;

  // Advance to just after the next rising edge; outputs of that edge are settled.
  task automatic step();
    @(posedge clk_1x);
    #1;
  endtask

  task automatic test_reset();
    logic [3:0] obs;
    reset_1x_n            = 1'b0;
    bus_if.button         = 1'b1;
    bus_if.sw_reset_req   = 1'b0;
    bus_if.sw_reset_key   = 8'h00;
    bus_if.cause_clear    = 1'b0;
    repeat (3) step();
    obs = {bus_if.reset_request, bus_if.button_pressed, bus_if.reset_cause};
    n_checks++;
    if (obs !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_state got=%b exp=0000", obs);
    end
    reset_1x_n = 1'b1;
    for (int i = 0; i < 100; i++) begin
      step();
      obs = {bus_if.reset_request, bus_if.button_pressed, bus_if.reset_cause};
      n_checks++;
      if (obs !== 4'b0000) begin
        n_fail++;
        $display("FAIL idle_after_reset cyc=%0d got=%b exp=0000", i, obs);
      end
    end
  endtask

  task automatic test_glitch();
    logic [1:0] obs;
    for (int g = 0; g < 4; g++) begin
      for (int c = 0; c < 6; c++) begin
        bus_if.button = (c < 3) ? 1'b0 : 1'b1;
        step();
        obs = {bus_if.reset_request, bus_if.button_pressed};
        n_checks++;
        if (obs !== 2'b00) begin
          n_fail++;
          $display("FAIL glitch g=%0d c=%0d got=%b exp=00", g, c, obs);
        end
      end
    end
    bus_if.button = 1'b1;
    repeat (6) step();
  endtask

  // Clean press of 5 cycles: pressed rises 6 edges after the raw edge, falls at
  // edge 11; request high on edges 7..14.
  task automatic test_clean_press();
    logic exp_bp, exp_req, prev;
    int   rises, highs;
    rises = 0; highs = 0; prev = 1'b0;
    bus_if.button = 1'b0;
    for (int k = 1; k <= 24; k++) begin
      step();
      exp_bp  = (k >= 6) && (k <= 10);
      exp_req = (k >= 7) && (k <= 14);
      n_checks++;
      if ({bus_if.button_pressed, bus_if.reset_request} !== {exp_bp, exp_req}) begin
        n_fail++;
        $display("FAIL clean_press k=%0d got bp/req=%b%b exp=%b%b", k,
                 bus_if.button_pressed, bus_if.reset_request, exp_bp, exp_req);
      end
      if (bus_if.reset_request && !prev) rises++;
      if (bus_if.reset_request) highs++;
      prev = bus_if.reset_request;
      if (k == 5) bus_if.button = 1'b1;
    end
    n_checks++;
    if (highs != 8 || rises != 1) begin
      n_fail++;
      $display("FAIL clean_press_width got highs=%0d rises=%0d exp highs=8 rises=1", highs, rises);
    end
    n_checks++;
    if (bus_if.reset_cause !== 2'b01) begin
      n_fail++;
      $display("FAIL clean_press_cause got=%b exp=01", bus_if.reset_cause);
    end
  endtask

  // Press of 40 cycles: pressed 6..45, request 7..46 (falls at 47).
  task automatic test_hold();
    logic exp_bp, exp_req, prev;
    int   rises;
    rises = 0; prev = 1'b0;
    bus_if.button = 1'b0;
    for (int k = 1; k <= 56; k++) begin
      step();
      exp_bp  = (k >= 6) && (k <= 45);
      exp_req = (k >= 7) && (k <= 46);
      n_checks++;
      if ({bus_if.button_pressed, bus_if.reset_request} !== {exp_bp, exp_req}) begin
        n_fail++;
        $display("FAIL hold k=%0d got bp/req=%b%b exp=%b%b", k,
                 bus_if.button_pressed, bus_if.reset_request, exp_bp, exp_req);
      end
      if (bus_if.reset_request && !prev) rises++;
      prev = bus_if.reset_request;
      if (k == 40) bus_if.button = 1'b1;
    end
    n_checks++;
    if (rises != 1) begin
      n_fail++;
      $display("FAIL hold_single_request got=%0d exp=1", rises);
    end
  endtask

  task automatic test_sw();
    logic exp_req;
    int   highs;
    highs = 0;
    // Wrong key: nothing happens, cause keeps its previous value.
    bus_if.sw_reset_req = 1'b1;
    bus_if.sw_reset_key = 8'h00;
    step();
    bus_if.sw_reset_req = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      n_checks++;
      if ({bus_if.reset_request, bus_if.reset_cause} !== 3'b001) begin
        n_fail++;
        $display("FAIL sw_wrong_key k=%0d got req/cause=%b%b exp=1'b0 01", k,
                 bus_if.reset_request, bus_if.reset_cause);
      end
      step();
    end
    // Valid key, then a second valid strobe mid-pulse (sampled at edge 5).
    bus_if.sw_reset_req = 1'b1;
    bus_if.sw_reset_key = 8'hA5;
    for (int k = 1; k <= 12; k++) begin
      step();
      bus_if.sw_reset_req = (k == 4) ? 1'b1 : 1'b0;
      exp_req = (k <= 8);
      n_checks++;
      if (bus_if.reset_request !== exp_req) begin
        n_fail++;
        $display("FAIL sw_pulse k=%0d got=%b exp=%b", k, bus_if.reset_request, exp_req);
      end
      n_checks++;
      if (bus_if.reset_cause !== 2'b10) begin
        n_fail++;
        $display("FAIL sw_cause k=%0d got=%b exp=10", k, bus_if.reset_cause);
      end
      if (bus_if.reset_request) highs++;
    end
    n_checks++;
    if (highs != 8) begin
      n_fail++;
      $display("FAIL sw_width got=%0d exp=8", highs);
    end
  endtask

  // Button event reaches the FSM at edge 7; a valid SW strobe is sampled on that edge too.
  task automatic test_simultaneous();
    logic exp_req;
    bus_if.button = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (k == 5) bus_if.button = 1'b1;
      bus_if.sw_reset_req = (k == 6) ? 1'b1 : 1'b0;
      bus_if.sw_reset_key = 8'hA5;
      exp_req = (k >= 7) && (k <= 14);
      n_checks++;
      if (bus_if.reset_request !== exp_req) begin
        n_fail++;
        $display("FAIL simul_req k=%0d got=%b exp=%b", k, bus_if.reset_request, exp_req);
      end
      if (k >= 7) begin
        n_checks++;
        if (bus_if.reset_cause !== 2'b11) begin
          n_fail++;
          $display("FAIL simul_cause k=%0d got=%b exp=11", k, bus_if.reset_cause);
        end
      end
    end
  endtask

  task automatic test_clear_and_async_reset();
    // Plain clear in IDLE.
    bus_if.cause_clear = 1'b1;
    step();
    bus_if.cause_clear = 1'b0;
    n_checks++;
    if (bus_if.reset_cause !== 2'b00) begin
      n_fail++;
      $display("FAIL cause_clear got=%b exp=00", bus_if.reset_cause);
    end
    // Clear together with a new SW event: the event wins.
    bus_if.cause_clear  = 1'b1;
    bus_if.sw_reset_req = 1'b1;
    bus_if.sw_reset_key = 8'hA5;
    step();
    bus_if.cause_clear  = 1'b0;
    bus_if.sw_reset_req = 1'b0;
    n_checks++;
    if ({bus_if.reset_request, bus_if.reset_cause} !== 3'b110) begin
      n_fail++;
      $display("FAIL clear_vs_event got req/cause=%b%b exp=1 10",
               bus_if.reset_request, bus_if.reset_cause);
    end
    repeat (3) step();
    n_checks++;
    if (bus_if.reset_request !== 1'b1) begin
      n_fail++;
      $display("FAIL pre_async_req got=%b exp=1", bus_if.reset_request);
    end
    // Asynchronous reset mid-pulse, between clock edges.
    reset_1x_n = 1'b0;
    #1;
    n_checks++;
    if ({bus_if.reset_request, bus_if.button_pressed, bus_if.reset_cause} !== 4'b0000) begin
      n_fail++;
      $display("FAIL async_reset got=%b exp=0000",
               {bus_if.reset_request, bus_if.button_pressed, bus_if.reset_cause});
    end
    step();
    reset_1x_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      step();
      n_checks++;
      if ({bus_if.reset_request, bus_if.reset_cause} !== 3'b000) begin
        n_fail++;
        $display("FAIL post_async k=%0d got=%b exp=000", k,
                 {bus_if.reset_request, bus_if.reset_cause});
      end
    end
  endtask

  // Button held through reset release is debounced as a new press: pressed 6..21,
  // request 7..22 (pulse then HOLD), released after edge 16.
  task automatic test_held_through_reset();
    logic exp_bp, exp_req, prev;
    int   rises;
    rises = 0; prev = 1'b0;
    reset_1x_n    = 1'b0;
    bus_if.button = 1'b0;
    repeat (3) step();
    reset_1x_n = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      step();
      exp_bp  = (k >= 6) && (k <= 21);
      exp_req = (k >= 7) && (k <= 22);
      n_checks++;
      if ({bus_if.button_pressed, bus_if.reset_request} !== {exp_bp, exp_req}) begin
        n_fail++;
        $display("FAIL held_reset k=%0d got bp/req=%b%b exp=%b%b", k,
                 bus_if.button_pressed, bus_if.reset_request, exp_bp, exp_req);
      end
      if (bus_if.reset_request && !prev) rises++;
      prev = bus_if.reset_request;
      if (k == 16) bus_if.button = 1'b1;
    end
    n_checks++;
    if (rises != 1 || bus_if.reset_cause !== 2'b01) begin
      n_fail++;
      $display("FAIL held_reset_summary got rises=%0d cause=%b exp rises=1 cause=01",
               rises, bus_if.reset_cause);
    end
  endtask

  initial begin
    test_reset();
    test_glitch();
    test_clean_press();
    test_hold();
    test_sw();
    test_simultaneous();
    test_clear_and_async_reset();
    test_held_through_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
